// File: rtl/prio_enc_display_if.sv
// rtl/prio_enc_display_if.sv - switch vector in, priority index and segment outputs
interface prio_enc_display_if #(
    parameter int IN_W   = 8,
    parameter int DIGITS = 1
);
    localparam int IDX_W = $clog2(IN_W);

    logic [IN_W-1:0]     in;
    logic [IDX_W-1:0]    idx;
    logic                valid;
    logic                changed;
    logic [7*DIGITS-1:0] hex;
    logic [6:0]          hv;

    modport master (output in, input idx, valid, changed, hex, hv);
    modport slave  (input in, output idx, valid, changed, hex, hv);
endinterface

// File: rtl/prio_enc_display.sv
// rtl/prio_enc_display.sv - debounced priority encoder driving hex and status digits
module prio_enc_display #(
    parameter int IN_W      = 8,
    parameter int DIGITS    = 1,
    parameter int DEB_CYC   = 4,
    parameter int BLINK_CYC = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    prio_enc_display_if.slave    bus
);
    localparam int IDX_W = $clog2(IN_W);
    localparam int NIB_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(DEB_CYC + 1);
    localparam int BC_W  = $clog2(BLINK_CYC);

    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEB_CYC);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYC - 1);
    localparam logic [BC_W-1:0]  BC_LAST  = BC_W'(BLINK_CYC - 1);

    logic [IN_W-1:0]  s1, s2, cand, stable;
    logic [CNT_W-1:0] cnt;
    logic [IDX_W-1:0] enc, idx_q;
    logic             valid_q, changed_q;
    logic [BC_W-1:0]  bc;
    logic             phase;
    logic [NIB_W-1:0] idx_ext;
    logic             any_set;

    function automatic logic [6:0] seg7(input logic [3:0] n);
        case (n)
            4'h0:    seg7 = 7'h40;
            4'h1:    seg7 = 7'h79;
            4'h2:    seg7 = 7'h24;
            4'h3:    seg7 = 7'h30;
            4'h4:    seg7 = 7'h19;
            4'h5:    seg7 = 7'h12;
            4'h6:    seg7 = 7'h02;
            4'h7:    seg7 = 7'h78;
            4'h8:    seg7 = 7'h00;
            4'h9:    seg7 = 7'h10;
            4'hA:    seg7 = 7'h08;
            4'hB:    seg7 = 7'h03;
            4'hC:    seg7 = 7'h46;
            4'hD:    seg7 = 7'h21;
            4'hE:    seg7 = 7'h06;
            default: seg7 = 7'h0E;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= bus.in;
            s2 <= s1;
        end
    end

    // Any difference at s2 restarts qualification; stable loads on the edge cnt reaches DEB_CYC.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cand   <= '0;
            cnt    <= '0;
            stable <= '0;
        end else if (s2 != cand) begin
            cand <= s2;
            cnt  <= '0;
        end else if (cnt < CNT_MAX) begin
            cnt <= cnt + CNT_W'(1);
            if (cnt == CNT_LAST)
                stable <= cand;
        end
    end

    // Ascending scan so the highest set bit wins.
    always_comb begin
        enc = '0;
        for (int i = 0; i < IN_W; i++)
            if (stable[i])
                enc = IDX_W'(i);
    end

    assign any_set = |stable;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx_q     <= '0;
            valid_q   <= 1'b0;
            changed_q <= 1'b0;
        end else begin
            idx_q     <= enc;
            valid_q   <= any_set;
            changed_q <= (enc != idx_q) || (any_set != valid_q);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bc    <= '0;
            phase <= 1'b1;
        end else if (valid_q) begin
            bc    <= '0;
            phase <= 1'b1;
        end else if (bc == BC_LAST) begin
            bc    <= '0;
            phase <= ~phase;
        end else begin
            bc <= bc + BC_W'(1);
        end
    end

    assign idx_ext = NIB_W'(idx_q);

    always_comb begin
        bus.hex = '1;
        for (int k = 0; k < DIGITS; k++)
            bus.hex[7*k +: 7] = valid_q ? seg7(idx_ext[4*k +: 4]) : 7'h7F;
        bus.hv = valid_q ? 7'h79 : (phase ? 7'h3F : 7'h7F);
    end

    assign bus.idx     = idx_q;
    assign bus.valid   = valid_q;
    assign bus.changed = changed_q;
endmodule

// File: tb/tb_prio_enc_display.sv
// tb/tb_prio_enc_display.sv - scoreboard bench for default and 32-bit configurations
module tb_prio_enc_display;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    prio_enc_display_if #(.IN_W(8),  .DIGITS(1)) b8();
    prio_enc_display_if #(.IN_W(32), .DIGITS(2)) b32();

    prio_enc_display #(.IN_W(8), .DIGITS(1), .DEB_CYC(4), .BLINK_CYC(8)) dut8 (
        .clk(clk), .rst(rst), .bus(b8.slave)
    );
    prio_enc_display #(.IN_W(32), .DIGITS(2), .DEB_CYC(4), .BLINK_CYC(8)) dut32 (
        .clk(clk), .rst(rst), .bus(b32.slave)
    );

    typedef struct {
        logic [7:0]  idx;
        logic        valid;
        logic [13:0] hex;
        logic [6:0]  hv;
    } exp_t;

    exp_t q8[$];
    exp_t q32[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic push8(input logic [7:0] i, input logic v, input logic [6:0] h, input logic [6:0] s);
        exp_t e;
        e.idx = i; e.valid = v; e.hex = {7'h7F, h}; e.hv = s;
        q8.push_back(e);
    endtask

    task automatic push32(input logic [7:0] i, input logic v, input logic [13:0] h, input logic [6:0] s);
        exp_t e;
        e.idx = i; e.valid = v; e.hex = h; e.hv = s;
        q32.push_back(e);
    endtask

    task automatic drain(input string nm, input int budget);
        int n = 0;
        while ((q8.size() != 0 || q32.size() != 0) && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        checks++;
        if (q8.size() != 0 || q32.size() != 0) begin
            errors++;
            $display("FAIL %s timeout pending8 %0d pending32 %0d expected 0", nm, q8.size(), q32.size());
            q8.delete();
            q32.delete();
        end
    endtask

    always @(negedge clk) begin
        if (rst && b8.changed) begin
            if (q8.size() == 0) begin
                checks++; errors++;
                $display("FAIL chg8_unexpected idx %0d valid %0b expected no pulse at %0t", b8.idx, b8.valid, $time);
            end else begin
                exp_t e;
                e = q8.pop_front();
                chk("mon8_idx",   32'(b8.idx),   32'(e.idx));
                chk("mon8_valid", 32'(b8.valid), 32'(e.valid));
                chk("mon8_hex",   32'(b8.hex),   32'(e.hex[6:0]));
                chk("mon8_hv",    32'(b8.hv),    32'(e.hv));
            end
        end
    end

    always @(negedge clk) begin
        if (rst && b32.changed) begin
            if (q32.size() == 0) begin
                checks++; errors++;
                $display("FAIL chg32_unexpected idx %0d valid %0b expected no pulse at %0t", b32.idx, b32.valid, $time);
            end else begin
                exp_t e;
                e = q32.pop_front();
                chk("mon32_idx",   32'(b32.idx),   32'(e.idx));
                chk("mon32_valid", 32'(b32.valid), 32'(e.valid));
                chk("mon32_hex",   32'(b32.hex),   32'(e.hex));
                chk("mon32_hv",    32'(b32.hv),    32'(e.hv));
            end
        end
    end

    initial begin
        b8.in  = 8'hFF;
        b32.in = '0;
        rst    = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("rst_idx",     32'(b8.idx),     0);
            chk("rst_valid",   32'(b8.valid),   0);
            chk("rst_changed", 32'(b8.changed), 0);
            chk("rst_hex",     32'(b8.hex),     32'h7F);
            chk("rst_hv",      32'(b8.hv),      32'h3F);
            chk("rst_hex32",   32'(b32.hex),    32'h3FFF);
        end
        rst   = 1'b1;
        b8.in = 8'h00;
        repeat (12) @(negedge clk);
        chk("idle_valid", 32'(b8.valid), 0);

        // latency: valid must rise on exactly the 8th edge
        b8.in = 8'b0010_0110;
        push8(8'd5, 1'b1, 7'h12, 7'h79);
        repeat (7) @(negedge clk);
        chk("lat7_valid", 32'(b8.valid), 0);
        @(negedge clk);
        chk("lat8_idx",     32'(b8.idx),     5);
        chk("lat8_valid",   32'(b8.valid),   1);
        chk("lat8_changed", 32'(b8.changed), 1);
        chk("lat8_hex",     32'(b8.hex),     32'h12);
        chk("lat8_hv",      32'(b8.hv),      32'h79);
        @(negedge clk);
        chk("lat9_changed", 32'(b8.changed), 0);
        drain("lat_drain", 5);

        b8.in = 8'b1000_0001;
        push8(8'd7, 1'b1, 7'h78, 7'h79);
        drain("prio_msb", 20);
        b8.in = 8'b0000_0001;
        push8(8'd0, 1'b1, 7'h40, 7'h79);
        drain("prio_lsb", 20);
        repeat (4) @(negedge clk);
        chk("prio_lsb_valid", 32'(b8.valid), 1);

        b8.in = 8'h04;
        push8(8'd2, 1'b1, 7'h24, 7'h79);
        drain("deb_base", 20);
        @(negedge clk);
        b8.in = 8'h80;
        repeat (3) @(negedge clk);
        b8.in = 8'h04;
        repeat (20) @(negedge clk);
        chk("deb_glitch_idx", 32'(b8.idx), 2);
        b8.in = 8'h80;
        push8(8'd7, 1'b1, 7'h78, 7'h79);
        repeat (10) @(negedge clk);
        chk("deb_hold_idx", 32'(b8.idx), 7);
        drain("deb_hold", 5);

        // blink: the drain exits just after the edge where valid fell
        b8.in = 8'h00;
        push8(8'd0, 1'b0, 7'h7F, 7'h3F);
        drain("blink_fall", 20);
        for (int j = 1; j <= 43; j++) begin
            @(negedge clk);
            chk("blink_hv", 32'(b8.hv), ((j / 8) % 2 == 0) ? 32'h3F : 32'h7F);
            if (j % 8 == 0)
                chk("blink_hex", 32'(b8.hex), 32'h7F);
        end
        #1 rst = 1'b0;
        #1;
        chk("blink_rst_hv",    32'(b8.hv),    32'h3F);
        chk("blink_rst_valid", 32'(b8.valid), 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);

        b32.in = 32'h0001_0000;
        push32(8'd16, 1'b1, {7'h79, 7'h40}, 7'h79);
        drain("wide_16", 20);
        b32.in = 32'h8000_0000;
        push32(8'd31, 1'b1, {7'h79, 7'h0E}, 7'h79);
        drain("wide_31", 20);
        repeat (5) @(negedge clk);
        chk("wide_final_idx", 32'(b32.idx), 31);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/prio_enc_display.md
# prio_enc_display

Parametrised, clocked successor to the 8-to-3 priority-encoder display path. It synchronises and debounces an `IN_W`-bit switch vector and finds the index of its highest set bit. The index is shown in hex on `DIGITS` seven-segment digits, and a status digit blinks a dash while no input is set. It sits between the board switch inputs and the segment outputs in `top`.

## Interface
- `IN_W`, 8, input vector width; power of two, 2..256; `IDX_W = $clog2(IN_W)`
- `DIGITS`, 1, hex index digits; must satisfy `4*DIGITS >= IDX_W`
- `DEB_CYC`, 4, debounce length in cycles; must be >= 1
- `BLINK_CYC`, 8, status-digit half-period in cycles; must be >= 2
- `clk`  in  1  single clock; all state updates on rising edge
- `rst`  in  1  reset, asynchronous, active-low
- `in`  in  `IN_W`  raw switch vector, asynchronous to `clk`
- `idx`  out  `IDX_W`  registered index of highest set bit of the debounced vector
- `valid`  out  1  registered; 1 when the debounced vector is non-zero
- `changed`  out  1  one-cycle pulse when `idx` or `valid` takes a new value
- `hex`  out  `7*DIGITS`  active-low `gfedcba` segments; digit k is `hex[7k+6:7k]`
- `hv`  out  7  active-low status digit

## Operation
- Synchroniser: two flops, `s1 <= in` then `s2 <= s1`.
- Debounce: `cand` register plus `cnt` counter, which saturates at `DEB_CYC`.
  - If `s2 != cand`: load `cand <= s2` and `cnt <= 0`.
  - Else if `cnt < DEB_CYC`: `cnt <= cnt+1`. If `cnt == DEB_CYC-1`, also load `stable <= cand` on the same edge.
  - Else hold.
- Encoder: MSB has priority. The combinational `enc` is the highest i with `stable[i]=1`, or 0 if none. On each edge:
  - `idx <= enc`
  - `valid <= |stable`
  - `changed <= (enc != idx) || (|stable != valid)`
- Blink: counter `bc` (0..`BLINK_CYC-1`) and bit `phase`.
  - While `valid=1`: `bc <= 0`, `phase <= 1`.
  - While `valid=0`: `bc` increments; on wrap `BLINK_CYC-1 -> 0`, `phase` toggles.
- Segment decode (combinational from registered state, no added latency):
  - When `valid=1`: digit k shows `idx` zero-extended, nibble `[4k+3:4k]`; `hv = 7'h79` ("1").
  - When `valid=0`: all `hex` digits show `7'h7F` (blank); `hv = phase ? 7'h3F : 7'h7F` (dash / blank).
- Hex patterns 0..F: `40,79,24,30,19,12,02,78,00,10,08,03,46,21,06,0E`.
- Unused high nibbles show "0" (`7'h40`).

## Timing
- Reset (asynchronous assert, any time, including mid-debounce or mid-blink):
  - `s1`, `s2`, `cand`, `stable` = 0; `cnt` = 0; `bc` = 0; `phase` = 1.
  - `idx` = 0, `valid` = 0, `changed` = 0.
  - Hence `hex` = all `7'h7F` and `hv` = `7'h3F` during and immediately after reset.
  - Release is synchronous to the next rising edge; a pending debounce is discarded.
- Latency: `in` changes before edge E1.
  - `s1` updates at E1, `s2` at E2, `cand` at E3.
  - `stable` at E3+`DEB_CYC`; `idx`/`valid`/`changed` at E4+`DEB_CYC`.
  - Default settings: 8 edges.
- Glitches:
  - A change lasting fewer than `DEB_CYC+1` cycles at `s2` never reaches `stable`.
  - A glitch that returns to the old value re-qualifies the old value; `changed` stays 0.
- Simultaneous events: new bits anywhere in the vector restart the full debounce; the priority result comes only from `stable`.
- Blink: `hv` first goes blank `BLINK_CYC` edges after `valid` falls, then alternates every `BLINK_CYC` edges.
- `changed` is never high on two consecutive cycles unless `stable` changed on two consecutive edges. That cannot happen when `DEB_CYC >= 1`.

## Test plan
- Reset: hold `rst=0` for 3 cycles with `in=8'hFF` -> `idx=0`, `valid=0`, `hex=7'h7F`, `hv=7'h3F` throughout; `changed=0`.
- Basic latency (defaults): `in` 0 -> `8'b0010_0110` -> after exactly 8 edges `idx=5`, `valid=1`, `changed` pulses 1 cycle, `hex=7'h12`, `hv=7'h79`.
- Priority: `in=8'b1000_0001` -> `idx=7`, `hex=7'h78`. Then `8'b0000_0001` -> `idx=0`, `hex=7'h40`, `valid=1`, one `changed` pulse.
- Debounce:
  - Starting from `in=8'h04`, pulse `in=8'h80` for 3 cycles, then return -> `idx` stays 2, `changed` never asserts.
  - Hold `8'h80` for 10 cycles -> `idx=7`.
- Blink: from `valid=1`, set `in=0` -> `valid=0`, `hex` blank, `hv` alternates `7'h3F` / `7'h7F` every 8 cycles for at least 4 periods.
  - Assert `rst` mid-period -> `hv=7'h3F` immediately.
- Wide config (`IN_W=32`, `DIGITS=2`): `in=32'h0001_0000` -> `idx=16`, digit0 = `7'h40`, digit1 = `7'h79`.
  - Then `in=32'h8000_0000` -> `idx=31`, digits `7'h79` (1) and `7'h0E` (F).
